div_gen_seq: RTL and testbench

Sequential unsigned integer divider, the inverse operation of the multiplier in the `mul` arithmetic library. It latches a dividend and a divisor on a start strobe and runs a radix-2 restoring division, one quotient bit per clock. It then presents the quotient and remainder with a one-cycle done pulse. It sits beside the multiplier as the divide half of the unsigned arithmetic unit, and is driven by the same controller through a start/busy/done handshake.

---
 rtl/div_gen_seq.sv | 145 ++++++++++++++
 tb/tb_div_gen_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_gen_seq.sv
// div_gen_seq: sequential unsigned radix-2 restoring divider.
// One quotient bit per clock; WIDTH-cycle latency; start/busy/done handshake.
// Optional feature macro: DIV_GEN_SEQ_ZERO_FAST_EN
//   defined   -> a start with B==0 completes at the acceptance edge (no RUN pass)
//   undefined -> B==0 runs the normal WIDTH-step path (same Q/R/DIV_ZERO values)
//
// Handshake: START is looked at only while BUSY==0; the edge that sees
// START=1 with BUSY=0 is the acceptance edge and captures A/B. DONE is a
// single-cycle pulse; Q/R/DIV_ZERO change only on the edge that raises DONE
// and hold until the next completion. START during BUSY is dropped.
module div_gen_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIV_ZERO,
  output logic [0:0]       DBG_STATE
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

`ifdef DIV_GEN_SEQ_ZERO_FAST_EN
  localparam bit ZERO_FAST = 1'b1;
`else
  localparam bit ZERO_FAST = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend shifts out at the top while quotient bits shift in at the bottom,
  // so after WIDTH steps this register holds the full quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  // One restoring step worth of datapath.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             last_step;

  // Shift, trial-subtract and restore for the current RUN step.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    // rem_q[WIDTH] is always 0 after a step; it acts as the guard bit so the
    // sign of the trial difference lands in trial[WIDTH+1].
    trial     = {rem_q[WIDTH], rem_shift} - {2'b00, dvs_q};
    q_bit     = ~trial[WIDTH+1];
    rem_next  = q_bit ? trial[WIDTH:0] : rem_shift;
    dvd_next  = {dvd_q[WIDTH-2:0], q_bit};
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and result-capture logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START && ZERO_FAST && (B == '0)) begin
          // Divide-by-zero short cut: the restoring result is known up front.
          q_d    = '1;
          r_d    = A;
          dz_d   = 1'b1;
          done_d = 1'b1;
        end else if (START) begin
          state_d = S_RUN;
          dvd_d   = A;
          dvs_d   = B;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          q_d     = dvd_next;
          r_d     = rem_next[WIDTH-1:0];
          dz_d    = (dvs_q == '0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any division in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign BUSY      = (state_q == S_RUN);
  assign DONE      = done_q;
  assign Q         = q_q;
  assign R         = r_q;
  assign DIV_ZERO  = dz_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_div_gen_seq.sv
// tb_div_gen_seq: directed and random bench for div_gen_seq (WIDTH=32).
// A cycle-level reference model built from floor division and a latency
// countdown is compared against the DUT on every falling edge.
module tb_div_gen_seq;

  localparam int W = 32;

`ifdef DIV_GEN_SEQ_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A, B;
  logic         BUSY, DONE, DIV_ZERO;
  logic [W-1:0] Q, R;
  logic [0:0]   DBG_STATE;

  always #5 CLK = ~CLK;

  div_gen_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIV_ZERO(DIV_ZERO),
    .DBG_STATE(DBG_STATE)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  logic [2*W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // ---------------- reference model ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dz   = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic [W-1:0] p_q, p_r;
  logic         p_dz;
  int           m_cnt  = 0;

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = '0; m_r = '0; m_cnt = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (START) begin
        if (B == 0) begin
          p_q = '1; p_r = A; p_dz = 1'b1;
        end else begin
          p_q = A / B; p_r = A % B; p_dz = 1'b0;
        end
        exp_q.push_back({p_dz, p_r, p_q});
        if (FAST && B == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end else begin
          m_busy = 1'b1; m_cnt = W;
        end
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  initial forever begin
    logic [2*W:0] e;
    @(negedge CLK);
    check("busy", BUSY, m_busy);
    check("done", DONE, m_done);
    check("q", Q, m_q);
    check("r", R, m_r);
    check("div_zero", DIV_ZERO, m_dz);
    if (DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got DONE=1 expected no completion (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_q", Q, e[W-1:0]);
        check("sb_r", R, e[2*W-1:W]);
        check("sb_dz", DIV_ZERO, e[2*W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (DONE !== 1'b1 && n < W + 4) begin
      @(negedge CLK);
      n++;
    end
    lat = cyc - t0;
    if (DONE !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", W + 4);
    end
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) cnt++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int lat, nd, mode, zero_lat;
    logic [W-1:0] a, b;
    logic [63:0] recon;

    zero_lat = FAST ? 0 : W;
    RST_N = 1'b1; START = 1'b0; A = '0; B = '0;
    #1 RST_N = 1'b0;
    @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_dz", DIV_ZERO, 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);

    // 100 / 7
    start_div(32'd100, 32'd7);
    wait_done(lat);
    check("t1_lat", lat, W);
    check("t1_q", Q, 14);
    check("t1_r", R, 2);
    check("t1_dz", DIV_ZERO, 0);
    @(negedge CLK);

    // max / 1, then 3 / 10 started in the DONE cycle
    start_div(32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    check("t2_lat", lat, W);
    check("t2_q", Q, 64'hFFFF_FFFF);
    check("t2_r", R, 0);
    start_div(32'd3, 32'd10);
    wait_done(lat);
    check("t2b_lat", lat, W);
    check("t2b_q", Q, 0);
    check("t2b_r", R, 3);
    @(negedge CLK);

    // divide by zero
    start_div(32'd5, 32'd0);
    wait_done(lat);
    check("t3_lat", lat, zero_lat);
    check("t3_q", Q, 64'hFFFF_FFFF);
    check("t3_r", R, 5);
    check("t3_dz", DIV_ZERO, 1);
    @(negedge CLK);

    // START while busy is ignored; operand changes after acceptance too
    start_div(32'd1000, 32'd3);
    repeat (9) @(negedge CLK);
    A = 32'd9; B = 32'd9; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; A = '0; B = '0;
    wait_done(lat);
    check("t4_lat", lat, W);
    check("t4_q", Q, 333);
    check("t4_r", R, 1);
    check("t4_dz", DIV_ZERO, 0);
    count_dones(W + 5, nd);
    check("t4_single_done", nd, 0);

    // reset mid-operation
    start_div(32'd1000, 32'd3);
    repeat (14) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("t5_busy", BUSY, 0);
    check("t5_done", DONE, 0);
    check("t5_q", Q, 0);
    check("t5_r", R, 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    count_dones(W + 5, nd);
    check("t5_no_done", nd, 0);
    start_div(32'd50, 32'd8);
    wait_done(lat);
    check("t5b_q", Q, 6);
    check("t5b_r", R, 2);
    @(negedge CLK);

    // random pairs
    for (int k = 0; k < 1000; k++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin a = $urandom; b = 32'd1; end
        1: begin a = $urandom_range(0, 1000); b = a + $urandom_range(1, 5000); end
        2: begin a = $urandom; b = a; end
        3: begin a = $urandom; b = $urandom; end
        default: begin a = $urandom; b = $urandom_range(0, 255); end
      endcase
      start_div(a, b);
      wait_done(lat);
      check("rnd_lat", lat, (b == 0) ? zero_lat : W);
      if (b != 0) begin
        recon = 64'(Q) * 64'(b) + 64'(R);
        check("rnd_ident", recon, 64'(a));
        check("rnd_r_lt_b", 64'(R < b), 1);
      end else begin
        check("rnd_z_q", Q, 64'hFFFF_FFFF);
        check("rnd_z_r", R, 64'(a));
      end
    end
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
